// File: rtl/branch_cmp_pipe.sv
// Pipelined branch / SLT comparator: XLEN operands are compared one chunk per stage,
// MSB chunk first, carrying eq/lt accumulators and a hart tag down the pipe.
module branch_cmp_pipe #(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 2,
  parameter int TAG_W      = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_stall,
  input  logic             i_flush,
  input  logic             i_slt_op,
  input  logic             i_br_signed,
  input  logic             i_is_branch,
  input  logic [2:0]       i_funct3,
  input  logic [XLEN-1:0]  i_rd1,
  input  logic [XLEN-1:0]  i_rd2,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_slt,
  output logic             o_is_branch_valid
);

  localparam int CW = XLEN / NUM_STAGES;
  localparam int NR = (NUM_STAGES > 1) ? NUM_STAGES - 1 : 1;

  // Stage register k keeps only the bits not yet compared; this packs them end to end.
  function automatic int rem_off(input int k);
    int s;
    s = 0;
    for (int j = 0; j < k; j++) s += XLEN - (j + 1) * CW;
    return s;
  endfunction

  localparam int RTOT = (NUM_STAGES > 1) ? rem_off(NUM_STAGES - 1) : 1;

  logic [RTOT-1:0]     a_fwd, b_fwd;
  logic [NR-1:0]       v_fwd, eq_fwd, lt_fwd, slt_fwd, br_fwd;
  logic [NR*TAG_W-1:0] tag_fwd;
  logic [NR*3-1:0]     f3_fwd;

  logic             o_valid_q, o_slt_q, o_br_q;
  logic [TAG_W-1:0] o_tag_q;

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stg
      localparam int W = XLEN - gi * CW;
      logic [W-1:0]     a_in, b_in;
      logic             v_in, eq_in, lt_in, slt_in, br_in;
      logic [TAG_W-1:0] tag_in;
      logic [2:0]       f3_in;
      logic             eq_c, lt_c, eq_d, lt_d;

      if (gi == 0) begin : g_head
        // Sign-extend the MSB chunk by one bit so one signed compare covers both modes.
        logic signed [CW:0] a_x, b_x;
        assign a_in   = i_rd1;
        assign b_in   = i_rd2;
        assign v_in   = i_valid;
        assign eq_in  = 1'b1;
        assign lt_in  = 1'b0;
        assign slt_in = i_slt_op;
        assign br_in  = i_is_branch;
        assign tag_in = i_tag;
        assign f3_in  = i_funct3;
        assign a_x    = {i_br_signed & a_in[W-1], a_in[W-1 -: CW]};
        assign b_x    = {i_br_signed & b_in[W-1], b_in[W-1 -: CW]};
        assign lt_c   = a_x < b_x;
      end else begin : g_body
        assign a_in   = a_fwd[rem_off(gi-1) +: W];
        assign b_in   = b_fwd[rem_off(gi-1) +: W];
        assign v_in   = v_fwd[gi-1];
        assign eq_in  = eq_fwd[gi-1];
        assign lt_in  = lt_fwd[gi-1];
        assign slt_in = slt_fwd[gi-1];
        assign br_in  = br_fwd[gi-1];
        assign tag_in = tag_fwd[(gi-1)*TAG_W +: TAG_W];
        assign f3_in  = f3_fwd[(gi-1)*3 +: 3];
        assign lt_c   = a_in[W-1 -: CW] < b_in[W-1 -: CW];
      end

      assign eq_c = a_in[W-1 -: CW] == b_in[W-1 -: CW];
      assign eq_d = eq_in & eq_c;
      assign lt_d = lt_in | (eq_in & lt_c);

      if (gi < NUM_STAGES - 1) begin : g_reg
        logic [W-CW-1:0]  a_q, b_q;
        logic             v_q, eq_q, lt_q, slt_q, br_q;
        logic [TAG_W-1:0] tag_q;
        logic [2:0]       f3_q;

        always_ff @(posedge i_clk) begin
          if (!i_reset_n)   v_q <= 1'b0;
          else if (i_flush) v_q <= 1'b0;
          else if (!i_stall) v_q <= v_in;
          if (!i_stall) begin
            a_q   <= a_in[W-CW-1:0];
            b_q   <= b_in[W-CW-1:0];
            eq_q  <= eq_d;
            lt_q  <= lt_d;
            slt_q <= slt_in;
            br_q  <= br_in;
            tag_q <= tag_in;
            f3_q  <= f3_in;
          end
        end

        assign a_fwd[rem_off(gi) +: W-CW] = a_q;
        assign b_fwd[rem_off(gi) +: W-CW] = b_q;
        assign v_fwd[gi]                   = v_q;
        assign eq_fwd[gi]                  = eq_q;
        assign lt_fwd[gi]                  = lt_q;
        assign slt_fwd[gi]                 = slt_q;
        assign br_fwd[gi]                  = br_q;
        assign tag_fwd[gi*TAG_W +: TAG_W]  = tag_q;
        assign f3_fwd[gi*3 +: 3]           = f3_q;
      end else begin : g_out
        logic taken_d;

        always_comb begin
          taken_d = 1'b0;
          case (f3_in)
            3'b000:         taken_d = eq_d;
            3'b001:         taken_d = ~eq_d;
            3'b100, 3'b110: taken_d = lt_d;
            3'b101, 3'b111: taken_d = ~lt_d;
            default:        taken_d = 1'b0;
          endcase
          taken_d = taken_d & br_in;
        end

        always_ff @(posedge i_clk) begin
          if (!i_reset_n) begin
            o_valid_q <= 1'b0;
            o_slt_q   <= 1'b0;
            o_br_q    <= 1'b0;
            o_tag_q   <= '0;
          end else if (i_flush) begin
            o_valid_q <= 1'b0;
            o_slt_q   <= 1'b0;
            o_br_q    <= 1'b0;
          end else if (!i_stall) begin
            o_valid_q <= v_in;
            o_slt_q   <= v_in & (slt_in ? lt_d : 1'b1);
            o_br_q    <= v_in & taken_d;
            if (v_in) o_tag_q <= tag_in;
          end
        end
      end
    end
  endgenerate

  assign o_valid           = o_valid_q;
  assign o_tag             = o_tag_q;
  assign o_slt             = o_slt_q;
  assign o_is_branch_valid = o_br_q;

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Directed bench for branch_cmp_pipe (XLEN=32, NUM_STAGES=2): hand-computed results.
module tb_branch_cmp_pipe;

  localparam int XLEN = 32;
  localparam int NS   = 2;
  localparam int TW   = 4;

  logic            i_clk = 1'b0;
  logic            i_reset_n, i_valid, i_stall, i_flush;
  logic            i_slt_op, i_br_signed, i_is_branch;
  logic [TW-1:0]   i_tag;
  logic [2:0]      i_funct3;
  logic [XLEN-1:0] i_rd1, i_rd2;
  logic            o_valid, o_slt, o_is_branch_valid;
  logic [TW-1:0]   o_tag;

  int errors = 0;
  int checks = 0;

  branch_cmp_pipe #(.XLEN(XLEN), .NUM_STAGES(NS), .TAG_W(TW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_tag(i_tag),
    .i_stall(i_stall), .i_flush(i_flush), .i_slt_op(i_slt_op),
    .i_br_signed(i_br_signed), .i_is_branch(i_is_branch), .i_funct3(i_funct3),
    .i_rd1(i_rd1), .i_rd2(i_rd2), .o_valid(o_valid), .o_tag(o_tag),
    .o_slt(o_slt), .o_is_branch_valid(o_is_branch_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [TW-1:0] tag, input logic [2:0] f3,
                       input logic br, input logic slt, input logic sgn,
                       input logic [31:0] a, input logic [31:0] b);
    i_valid     = v;
    i_tag       = tag;
    i_funct3    = f3;
    i_is_branch = br;
    i_slt_op    = slt;
    i_br_signed = sgn;
    i_rd1       = a;
    i_rd2       = b;
  endtask

  // Single op into an idle pipe: nothing after one edge, result after NS edges.
  task automatic run_op(input string name, input logic [TW-1:0] tag, input logic [2:0] f3,
                        input logic br, input logic slt, input logic sgn,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic exp_taken, input logic exp_slt);
    drive(1'b1, tag, f3, br, slt, sgn, a, b);
    tick();
    i_valid = 1'b0;
    check({name, "_early_valid"}, 32'(o_valid), 32'd0);
    tick();
    check({name, "_valid"}, 32'(o_valid), 32'd1);
    check({name, "_tag"}, 32'(o_tag), 32'(tag));
    check({name, "_taken"}, 32'(o_is_branch_valid), 32'(exp_taken));
    check({name, "_slt"}, 32'(o_slt), 32'(exp_slt));
    $display("op %s tag=%0d valid=%0d taken=%0d slt=%0d", name, o_tag, o_valid,
             o_is_branch_valid, o_slt);
  endtask

  // One cycle of a BLTU stream against rd2=2, checked right after the edge.
  task automatic step(input string name, input logic v, input logic [TW-1:0] tag,
                      input logic stall, input logic flush, input logic [31:0] a,
                      input logic ev, input logic [TW-1:0] etag, input logic ebr);
    drive(v, tag, 3'b110, 1'b1, 1'b0, 1'b0, a, 32'd2);
    i_stall = stall;
    i_flush = flush;
    tick();
    check({name, "_valid"}, 32'(o_valid), 32'(ev));
    if (ev) begin
      check({name, "_tag"}, 32'(o_tag), 32'(etag));
      check({name, "_taken"}, 32'(o_is_branch_valid), 32'(ebr));
      check({name, "_slt"}, 32'(o_slt), 32'd1);
    end else begin
      check({name, "_taken_idle"}, 32'(o_is_branch_valid), 32'd0);
      check({name, "_slt_idle"}, 32'(o_slt), 32'd0);
    end
    $display("cyc %s stall=%0d flush=%0d valid=%0d tag=%0d taken=%0d", name, stall, flush,
             o_valid, o_tag, o_is_branch_valid);
  endtask

  initial begin
    i_reset_n = 1'b0;
    i_stall   = 1'b0;
    i_flush   = 1'b0;
    drive(1'b1, 4'd5, 3'b000, 1'b1, 1'b0, 1'b0, 32'h1234_0007, 32'h1234_0007);
    tick();
    tick();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_slt", 32'(o_slt), 32'd0);
    check("rst_taken", 32'(o_is_branch_valid), 32'd0);
    check("rst_tag", 32'(o_tag), 32'd0);
    $display("reset valid=%0d tag=%0d slt=%0d taken=%0d", o_valid, o_tag, o_slt,
             o_is_branch_valid);
    i_reset_n = 1'b1;

    run_op("blt_s",   4'd3, 3'b100, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1);
    run_op("bltu",    4'd3, 3'b110, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
    run_op("bgeu_lo", 4'd1, 3'b111, 1'b1, 1'b0, 1'b0, 32'h1234_0005, 32'h1234_0007, 1'b0, 1'b1);
    run_op("beq_ne",  4'd2, 3'b000, 1'b1, 1'b0, 1'b0, 32'h1234_0005, 32'h1234_0007, 1'b0, 1'b1);
    run_op("beq_eq",  4'd4, 3'b000, 1'b1, 1'b0, 1'b0, 32'h1234_0007, 32'h1234_0007, 1'b1, 1'b1);
    run_op("bne",     4'd6, 3'b001, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1);
    run_op("bge_s",   4'd7, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1);
    run_op("br_010",  4'd8, 3'b010, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    run_op("slt",     4'd9, 3'b010, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1);
    run_op("sltu",    4'hA, 3'b011, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
    run_op("plain",   4'hB, 3'b000, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);

    step("bb0", 1'b1, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0);
    step("bb1", 1'b1, 4'd1, 1'b0, 1'b0, 32'd1, 1'b1, 4'd0, 1'b1);
    step("bb2", 1'b1, 4'd2, 1'b1, 1'b0, 32'd2, 1'b1, 4'd0, 1'b1);
    step("bb3", 1'b1, 4'd2, 1'b1, 1'b0, 32'd2, 1'b1, 4'd0, 1'b1);
    step("bb4", 1'b1, 4'd2, 1'b0, 1'b0, 32'd2, 1'b1, 4'd1, 1'b1);
    step("bb5", 1'b1, 4'd3, 1'b0, 1'b0, 32'd3, 1'b1, 4'd2, 1'b0);
    step("bb6", 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd3, 1'b0);
    step("bb7", 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0);

    step("fl0", 1'b1, 4'd6, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0);
    step("fl1", 1'b1, 4'd7, 1'b0, 1'b0, 32'd0, 1'b1, 4'd6, 1'b1);
    step("fl2", 1'b1, 4'd8, 1'b1, 1'b1, 32'd0, 1'b0, 4'd0, 1'b0);
    step("fl3", 1'b1, 4'd9, 1'b0, 1'b0, 32'd5, 1'b0, 4'd0, 1'b0);
    step("fl4", 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b1, 4'd9, 1'b0);
    step("fl5", 1'b0, 4'd0, 1'b0, 1'b0, 32'd0, 1'b0, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_cmp_pipe.md
# branch_cmp_pipe

Parametrised, pipelined successor to the single-cycle branch/SLT comparator in the barrel-core execute path. Splits the XLEN-wide equality and less-than compare into NUM_STAGES chunk stages, MSB chunk first, so compare depth per cycle shrinks as XLEN grows. Each in-flight operation carries a hart tag, so an interleaved barrel pipeline can resolve branches and SLT/SLTU results per hart. Supports stall (freeze) and flush (kill in-flight).

## Interface
- XLEN, 32, operand width; must be divisible by NUM_STAGES.
- NUM_STAGES, 2, pipeline depth (1..4); chunk width CW = XLEN/NUM_STAGES.
- TAG_W, 4, hart/thread tag width.

- i_clk  in  1  clock; all state updates on rising edge.
- i_reset_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  operation present this cycle.
- i_tag  in  TAG_W  hart tag, returned unchanged with the result.
- i_stall  in  1  freeze all stages; input not accepted.
- i_flush  in  1  kill all in-flight ops and the op presented this cycle.
- i_slt_op  in  1  SLT/SLTU/SLTI/SLTIU operation.
- i_br_signed  in  1  signed compare (BLT/BGE/SLT) vs unsigned.
- i_is_branch  in  1  conditional branch opcode.
- i_funct3  in  3  branch condition select.
- i_rd1, i_rd2  in  XLEN  operands.
- o_valid  out  1  result valid.
- o_tag  out  TAG_W  tag of result.
- o_slt  out  1  less-than when slt_op, else 1 (for OR with SC result).
- o_is_branch_valid  out  1  branch taken.

## Operation
- Stage k (k=0..NUM_STAGES-1) compares chunk k, bits [XLEN-1-k*CW -: CW]; chunk 0 holds the MSB.
- Stage 0 extends chunk 0 by one bit: rd[XLEN-1] if i_br_signed, else 0; signed (CW+1)-bit compare. Other chunks: unsigned CW-bit compare.
- Accumulators: eq_acc starts 1, lt_acc starts 0; per stage lt_acc |= eq_acc & lt_chunk; eq_acc &= eq_chunk.
- Lower, not-yet-compared operand bits, tag, funct3, slt_op, is_branch and valid travel in the stage registers. Consumed bits are dropped.
- After the final stage: br_eq = eq_acc, br_lt = lt_acc.
- Branch decode when is_branch: 000→eq, 001→!eq, 100/110→lt, 101/111→!lt, 010/011→0. Not is_branch→0.
- o_slt = slt_op ? br_lt : 1.
- Output registers: when o_valid=0, o_slt=0 and o_is_branch_valid=0. o_tag holds its last value.
- Flush has priority over stall. On flush, all stage valids and o_valid clear next cycle. Data registers may keep stale values.
- Stall without flush: every register, including outputs, holds. i_valid is ignored that cycle; the upstream stage re-presents the op.

## Timing
- Latency NUM_STAGES cycles, input edge to o_valid. Output is registered at the last stage.
- Throughput 1 op/cycle when not stalled. No bubbles are inserted.
- Reset (i_reset_n=0 at edge): all valids, o_valid, o_slt, o_is_branch_valid and o_tag become 0. Reset mid-operation discards all in-flight ops. Reset overrides stall and flush.
- The op accepted in the cycle after a flush proceeds normally.
- NUM_STAGES=1 degenerates to a single registered full-width compare, latency 1.

## Test plan
- Reset: hold i_reset_n=0 two cycles with i_valid=1 → o_valid, o_slt, o_is_branch_valid and o_tag all 0. First valid op after release appears exactly NUM_STAGES cycles later.
- Signed/unsigned BLT, BLTU, tag=3:
  - rd1=0xFFFFFFFF, rd2=0x00000001, funct3=100, signed → taken=1.
  - Same operands, funct3=110, unsigned → taken=0.
  - Both results return o_tag=3 after 2 cycles.
- Chunk boundary, NUM_STAGES=2 (upper chunks equal, decision in the low chunk):
  - rd1=0x12340005, rd2=0x12340007, BGEU → 0.
  - Same operands, BEQ → 0.
  - rd1=rd2=0x12340007, BEQ → 1.
  - BNE with rd1=0x80000000, rd2=0 → 1.
- SLT path: slt_op=1, signed, rd1=0x80000000, rd2=0 → o_slt=1. SLTU with the same operands → o_slt=0. Non-SLT, non-branch op → o_slt=1, o_is_branch_valid=0.
- Back-to-back with stall: 4 ops with tags 0..3 on consecutive cycles, i_stall high 2 cycles mid-stream → results in order 0..3. Each result holds on the output during stall, with no duplicates and no drops.
- Flush: 2 ops in flight, pulse i_flush with a third op presented (i_stall also high) → none of the three produce o_valid. An op presented next cycle returns after NUM_STAGES cycles.
